// File: rtl/key_schedule_multi.sv
// key_schedule_multi: MacGuffin key-expansion controller with KEY_SLOTS round-key banks.
// A 2*BLK_W-bit key is expanded by streaming blocks through an external encryption
// core. The finished table is committed to the requested slot. round_keys shows the
// table of sel_slot.
// Optional feature: define KEY_SCHED_ZEROIZE_EN to add the zeroize / zeroize_slot inputs.
module key_schedule_multi #(
  parameter int ROUNDS    = 32,
  parameter int RK_W      = 48,
  parameter int BLK_W     = 64,
  parameter int KEY_SLOTS = 4,
  localparam int SLOT_W   = (KEY_SLOTS > 1) ? $clog2(KEY_SLOTS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [2*BLK_W-1:0]        key_tdata,
  input  logic [SLOT_W-1:0]         key_tslot,
  input  logic                      key_tvalid,
  output logic                      key_tready,
  output logic [BLK_W-1:0]          m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  input  logic [BLK_W-1:0]          s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  output logic [ROUNDS*RK_W-1:0]    work_round_keys,
  input  logic [SLOT_W-1:0]         sel_slot,
  output logic [ROUNDS*RK_W-1:0]    round_keys,
  output logic [KEY_SLOTS-1:0]      slot_ready,
`ifdef KEY_SCHED_ZEROIZE_EN
  input  logic                      zeroize,
  input  logic [SLOT_W-1:0]         zeroize_slot,
`endif
  output logic                      busy
);

  localparam int TBL_W = ROUNDS * RK_W;
  localparam int J_W   = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

  typedef enum logic [1:0] {IDLE, SEND, WAIT, COMMIT} state_t;

  state_t                  state_q, state_d;
  logic [BLK_W-1:0]        k1_q;
  logic [SLOT_W-1:0]       slot_q;
  logic [BLK_W-1:0]        block_q;
  logic                    half_q;
  logic [J_W-1:0]          j_q;
  logic [TBL_W-1:0]        work_q;
  logic [TBL_W-1:0]        slots_q [KEY_SLOTS];
  logic [KEY_SLOTS-1:0]    slot_ready_q;
  logic                    abort;
  logic                    last_round;

  // Zeroize of the slot currently being expanded aborts the expansion.
`ifdef KEY_SCHED_ZEROIZE_EN
  assign abort = zeroize && (state_q != IDLE) && (zeroize_slot == slot_q);
`else
  assign abort = 1'b0;
`endif

  assign last_round = (j_q == J_W'(ROUNDS - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (key_tvalid)    state_d = SEND;
      SEND:    if (m_axis_tready) state_d = WAIT;
      WAIT:    if (s_axis_tvalid) state_d = (last_round && half_q) ? COMMIT : SEND;
      COMMIT:                     state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  // Handshake and status outputs decoded from the state.
  always_comb begin
    key_tready    = (state_q == IDLE);
    m_axis_tvalid = (state_q == SEND);
    s_axis_tready = (state_q == WAIT);
    busy          = (state_q != IDLE);
  end

  // Key latch, block chaining, work-table accumulation, slot commit and zeroize.
  always_ff @(posedge clk) begin
    if (!rst) begin
      k1_q         <= '0;
      slot_q       <= '0;
      block_q      <= '0;
      half_q       <= 1'b0;
      j_q          <= '0;
      work_q       <= '0;
      slot_ready_q <= '0;
      for (int s = 0; s < KEY_SLOTS; s++) slots_q[s] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (key_tvalid) begin
            block_q <= key_tdata[2*BLK_W-1:BLK_W];
            k1_q    <= key_tdata[BLK_W-1:0];
            slot_q  <= key_tslot;
            half_q  <= 1'b0;
            j_q     <= '0;
            work_q  <= '0;
            for (int s = 0; s < KEY_SLOTS; s++)
              if (key_tslot == SLOT_W'(s)) slot_ready_q[s] <= 1'b0;
          end
        end
        WAIT: begin
          if (s_axis_tvalid) begin
            block_q <= s_axis_tdata;
            for (int r = 0; r < ROUNDS; r++)
              if (j_q == J_W'(r))
                work_q[r*RK_W +: RK_W] <= work_q[r*RK_W +: RK_W] ^ s_axis_tdata[BLK_W-1 -: RK_W];
            if (!last_round) begin
              j_q <= j_q + 1'b1;
            end else if (!half_q) begin
              half_q  <= 1'b1;
              j_q     <= '0;
              block_q <= k1_q;
            end
          end
        end
        COMMIT: begin
          for (int s = 0; s < KEY_SLOTS; s++)
            if (slot_q == SLOT_W'(s)) begin
              slots_q[s]      <= work_q;
              slot_ready_q[s] <= 1'b1;
            end
        end
        default: ;
      endcase
`ifdef KEY_SCHED_ZEROIZE_EN
      // Placed last so a zeroize overrides a same-cycle commit to that slot.
      if (zeroize) begin
        for (int s = 0; s < KEY_SLOTS; s++)
          if (zeroize_slot == SLOT_W'(s)) begin
            slots_q[s]      <= '0;
            slot_ready_q[s] <= 1'b0;
          end
      end
      if (abort) work_q <= '0;
`endif
    end
  end

  // Stored-table read mux; an out-of-range select yields all zeros.
  always_comb begin
    round_keys = '0;
    for (int s = 0; s < KEY_SLOTS; s++)
      if (sel_slot == SLOT_W'(s)) round_keys = slots_q[s];
  end

  assign m_axis_tdata    = block_q;
  assign work_round_keys = work_q;
  assign slot_ready      = slot_ready_q;

endmodule

// File: tb/tb_key_schedule_multi.sv
// Bench for key_schedule_multi with ROUNDS=4, RK_W=8, BLK_W=16, KEY_SLOTS=4.
// The encryption core is modelled as enc(x) = x + 16'h1111, so tables can be worked by hand:
//   key A = {k0=1234, k1=0000}: tops 23,34,45,56 ^ 11,22,33,44 -> table 32'h12761632
//   key B = {k0=A000, k1=0F00}: tops B1,C2,D3,E4 ^ 20,31,42,53 -> table 32'hB791F391
module tb_key_schedule_multi;
  localparam int ROUNDS = 4, RK_W = 8, BLK_W = 16, KEY_SLOTS = 4, SLOT_W = 2;
  localparam logic [31:0] KEY_A = 32'h1234_0000, TAB_A = 32'h1276_1632;
  localparam logic [31:0] KEY_B = 32'hA000_0F00, TAB_B = 32'hB791_F391;
  localparam int LAT = 2*ROUNDS*2 + 1;  // core answers one WAIT cycle after each block

  logic clk = 1'b0, rst = 1'b0;
  logic [2*BLK_W-1:0] key_tdata = '0;
  logic [SLOT_W-1:0] key_tslot = '0, sel_slot = '0;
  logic key_tvalid = 1'b0, key_tready;
  logic [BLK_W-1:0] m_axis_tdata, s_axis_tdata;
  logic m_axis_tvalid, m_axis_tready, s_axis_tvalid, s_axis_tready;
  logic [ROUNDS*RK_W-1:0] work_round_keys, round_keys;
  logic [KEY_SLOTS-1:0] slot_ready;
  logic busy;
`ifdef KEY_SCHED_ZEROIZE_EN
  logic zeroize = 1'b0;
  logic [SLOT_W-1:0] zeroize_slot = '0;
`endif

  int tests = 0, fails = 0;
  logic stall = 1'b0;

  key_schedule_multi #(.ROUNDS(ROUNDS), .RK_W(RK_W), .BLK_W(BLK_W), .KEY_SLOTS(KEY_SLOTS)) dut (
    .clk(clk), .rst(rst),
    .key_tdata(key_tdata), .key_tslot(key_tslot), .key_tvalid(key_tvalid), .key_tready(key_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .work_round_keys(work_round_keys), .sel_slot(sel_slot), .round_keys(round_keys),
    .slot_ready(slot_ready),
`ifdef KEY_SCHED_ZEROIZE_EN
    .zeroize(zeroize), .zeroize_slot(zeroize_slot),
`endif
    .busy(busy));

  always #5 clk = ~clk;

  // Encryption core model: inputs change on the falling edge only.
  initial begin
    logic have, mf, sf;
    logic [BLK_W-1:0] blk, mblk;
    have = 1'b0; mf = 1'b0; sf = 1'b0; blk = '0; mblk = '0;
    m_axis_tready = 1'b0; s_axis_tvalid = 1'b0; s_axis_tdata = '0;
    forever begin
      @(negedge clk);
      if (mf) begin have = 1'b1; blk = mblk; end
      if (sf) have = 1'b0;
      if (!busy) have = 1'b0;
      m_axis_tready = !have && (!stall || $urandom_range(0, 1) == 1);
      if (have) begin
        s_axis_tdata  = blk + 16'h1111;
        s_axis_tvalid = !stall || $urandom_range(0, 1) == 1;
      end else begin
        s_axis_tvalid = 1'b0;
      end
      mf = m_axis_tvalid && m_axis_tready;
      mblk = m_axis_tdata;
      sf = s_axis_tvalid && s_axis_tready;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_key(input logic [31:0] k, input logic [SLOT_W-1:0] s);
    key_tdata = k; key_tslot = s; key_tvalid = 1'b1;
    tick();
    key_tvalid = 1'b0;
  endtask

  task automatic wait_done(input logic [SLOT_W-1:0] s, input int limit, output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!slot_ready[s] && cyc < limit);
  endtask

  initial begin
    int cyc;
    // Reset state
    rst = 1'b0;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_mvalid", m_axis_tvalid, 0);
    check("rst_sready", s_axis_tready, 0);
    check("rst_ready", slot_ready, 0);
    check("rst_work", work_round_keys, 0);
    check("rst_rk", round_keys, 0);
    rst = 1'b1;
    tick();
    check("key_tready_idle", key_tready, 1);

    // Key A into slot 0, latency and table
    start_key(KEY_A, 2'd0);
    check("busy_after_accept", busy, 1);
    wait_done(2'd0, 200, cyc);
    check("latency_A", cyc, LAT);
    check("tab_A_slot0", round_keys, TAB_A);
    check("work_A", work_round_keys, TAB_A);
    check("idle_after_A", busy, 0);

    // Reload ready slot 0 with key B: bit clears at accept, old table stays
    start_key(KEY_B, 2'd0);
    check("reload_bit_clear", slot_ready[0], 0);
    check("reload_old_tab", round_keys, TAB_A);
    wait_done(2'd0, 200, cyc);
    check("latency_B", cyc, LAT);
    check("tab_B_slot0", round_keys, TAB_B);

    // Key input changed mid-expansion is ignored
    start_key(KEY_A, 2'd0);
    repeat (5) tick();
    key_tdata = $urandom; key_tslot = 2'd2; key_tvalid = 1'b1;
    tick();
    check("key_tready_busy", key_tready, 0);
    tick();
    key_tvalid = 1'b0;
    wait_done(2'd0, 200, cyc);
    check("midchange_tab", round_keys, TAB_A);
    check("midchange_ready", slot_ready, 4'b0001);

    // Reset during an expansion aborts everything
    start_key(KEY_B, 2'd2);
    repeat (6) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("abort_busy", busy, 0);
    check("abort_mvalid", m_axis_tvalid, 0);
    check("abort_ready", slot_ready, 0);
    check("abort_rk0", round_keys, 0);
    tick();
    start_key(KEY_A, 2'd0);
    wait_done(2'd0, 200, cyc);
    check("latency_after_rst", cyc, LAT);
    check("tab_after_rst", round_keys, TAB_A);

    // Two slots, independent tables
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    start_key(KEY_A, 2'd1);
    wait_done(2'd1, 200, cyc);
    start_key(KEY_B, 2'd3);
    wait_done(2'd3, 200, cyc);
    check("two_slots_ready", slot_ready, 4'b1010);
    sel_slot = 2'd1; #1;
    check("slot1_tab", round_keys, TAB_A);
    sel_slot = 2'd3; #1;
    check("slot3_tab", round_keys, TAB_B);
    sel_slot = 2'd2; #1;
    check("slot2_empty", round_keys, 0);
    start_key(KEY_B, 2'd1);
    check("reload1_ready", slot_ready, 4'b1000);
    sel_slot = 2'd1; #1;
    check("reload1_stale", round_keys, TAB_A);
    wait_done(2'd1, 200, cyc);
    check("reload1_tab", round_keys, TAB_B);
    sel_slot = 2'd3; #1;
    check("slot3_kept", round_keys, TAB_B);

    // Randomly stalled core gives the same table
    stall = 1'b1;
    start_key(KEY_A, 2'd2);
    wait_done(2'd2, 1000, cyc);
    stall = 1'b0;
    sel_slot = 2'd2; #1;
    check("stall_ready", slot_ready[2], 1);
    check("stall_tab", round_keys, TAB_A);

`ifdef KEY_SCHED_ZEROIZE_EN
    // Zeroize slot 3 while it is being expanded
    tick();
    start_key(KEY_A, 2'd3);
    repeat (4) tick();
    zeroize_slot = 2'd3; zeroize = 1'b1;
    tick();
    zeroize = 1'b0;
    check("zero_busy", busy, 0);
    check("zero_ready3", slot_ready[3], 0);
    check("zero_work", work_round_keys, 0);
    sel_slot = 2'd3; #1;
    check("zero_rk3", round_keys, 0);
    sel_slot = 2'd1; #1;
    check("zero_keeps1", round_keys, TAB_B);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute time guard.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
